mux_scan_sampler: RTL
=====================

Name: mux_scan_sampler

Overview:
Sequencer that sits directly upstream of the 4:1 `multiplexer` block and consumes its output. It drives the multiplexer's 2-bit `sel` through channels 0..3 in turn, holding each channel for DWELL cycles. At the end of each dwell it samples the mux output `signal`, then presents the assembled 4-bit frame to a downstream consumer over a valid/ready handshake. It supports single-shot and continuous scanning.

Parameters:
- DWELL, default 2: clock cycles `sel` is held per channel before sampling. Legal range 1..15.
- CNT_W, default 4: width of the dwell counter. Must satisfy 2^CNT_W > DWELL.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a scan; only honoured in IDLE.
- continuous  input  1  sampled at the output handshake edge. 1 = start the next scan immediately.
- signal  input  1  output of the 4:1 multiplexer.
- sel  output  2  channel select to the multiplexer.
- frame  output  4  sampled frame; bit i = `signal` value taken while sel == i.
- frame_valid  output  1  `frame` is valid and held stable.
- frame_ready  input  1  consumer accepts the frame.
- busy  output  1  high in SCAN and OUT.

Behaviour:
- Reset: synchronous `rst` wins over every other input, including mid-scan and mid-handshake. On reset:
  - state = IDLE
  - sel = 2'b00, frame = 4'b0000, frame_valid = 0, busy = 0
  - dwell counter, channel register and shadow register all cleared to 0
- All outputs are registered. `sel` equals the channel register.
- State machine:
  - IDLE: busy = 0, sel = 00. If start = 1 at an edge → SCAN, with channel = 0 and counter = 0.
  - SCAN: busy = 1, sel = channel.
    - Counter increments each cycle.
    - When counter == DWELL-1: set shadow[channel] = signal and clear the counter.
    - If channel < 3: channel increments.
    - If channel == 3: channel = 0; frame = shadow with bit 3 = signal (same edge); frame_valid = 1; go to OUT.
  - OUT: busy = 1, sel = 00, frame_valid = 1, frame held constant.
    - On an edge with frame_valid & frame_ready:
      - frame_valid drops.
      - If continuous = 1 → SCAN (channel 0, counter 0, shadow cleared), with no idle cycle.
      - Else → IDLE.
    - With no handshake, stay in OUT indefinitely.
- Latency:
  - start sampled at edge k; sel = 00 from edge k.
  - Channel i is sampled at edge k + (i+1)*DWELL.
  - frame_valid rises at edge k + 4*DWELL.
- Boundary rules:
  - start while busy is ignored, including start coincident with the handshake edge.
  - frame_ready high in the same cycle frame_valid rises completes the handshake at the next edge.
  - frame_ready while frame_valid = 0 has no effect.
  - DWELL = 1 samples every cycle: sel steps 00, 01, 10, 11 on consecutive cycles.
  - `frame` keeps its last value after the handshake until the next frame is loaded.

Decomposition:
- Shared package mux_scan_pkg holds:
  - state encoding: IDLE = 2'd0, SCAN = 2'd1, OUT = 2'd2
  - NUM_CH = 4
  - SEL_W = 2
- No sub-module: the counter and FSM fit in one module.
- The bench instantiates the existing `multiplexer` between `sel` and `signal` to close the loop.

Test Plan:
1. Inputs a1..a4 = 1,0,1,0, DWELL = 2, start pulse, frame_ready = 1 → sel sequence 00,00,01,01,10,10,11,11; frame = 4'b0101; frame_valid high 1 cycle; back to IDLE; busy = 0.
2. Inputs a1..a4 = 0,1,1,0, frame_ready = 0 for 5 cycles after valid → frame = 4'b0110 held stable with frame_valid = 1 until ready, then accepted on the first ready edge.
3. continuous = 1, inputs changed to 1,1,0,1 during the first OUT state → the second scan starts with no idle cycle; frames are 4'b0101 then 4'b1011.
4. rst asserted while sel = 10 mid-scan → next cycle all outputs are 0, state IDLE; a new start produces a clean full frame.
5. start re-pulsed during SCAN and during OUT → ignored; exactly one frame produced per accepted start.
6. DWELL = 1, inputs 1,1,1,1 → sel changes every cycle; frame_valid rises 4 cycles after the start edge; frame = 4'b1111.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
// State encoding is fixed so downstream debug taps can decode it.
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/mux_scan_sampler.sv
// Steps a 4:1 mux select through all channels, samples its output
// after each dwell, and hands the 4-bit frame off over valid/ready.
import mux_scan_pkg::*;

module mux_scan_sampler #(
  parameter int DWELL = 2,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic              signal,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] frame,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              busy
);

  if (DWELL < 1 || DWELL > 15 || (1 << CNT_W) <= DWELL) begin : g_bad_cfg
    $error("mux_scan_sampler: illegal DWELL/CNT_W");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic [NUM_CH-1:0]  shadow_q, shadow_d;
  logic [NUM_CH-1:0]  frame_q, frame_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    valid_d  = valid_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          cnt_d   = '0;
          ch_d    = '0;
        end
      end
      SCAN: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d          = '0;
          shadow_d[ch_q] = signal;
          if (ch_q == LAST_CH) begin
            // last channel bypasses the shadow so the frame loads this edge
            ch_d    = '0;
            frame_d = {signal, shadow_q[NUM_CH-2:0]};
            valid_d = 1'b1;
            state_d = OUT;
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OUT: begin
        if (valid_q && frame_ready) begin
          valid_d = 1'b0;
          if (continuous) begin
            state_d  = SCAN;
            cnt_d    = '0;
            ch_d     = '0;
            shadow_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ch_q     <= '0;
      shadow_q <= '0;
      frame_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ch_q     <= ch_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign sel         = ch_q;
  assign frame       = frame_q;
  assign frame_valid = valid_q;
  assign busy        = busy_q;

endmodule
